// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - LSTM sequence recurrence controller; define LSTM_HIST_EN for per-step h/c history.
module lstm_seq_ctrl #(
    parameter int WIDTH    = 32,
    parameter int NUM_X    = 2,
    parameter int NUM_H    = 1,
    parameter int CELL_LAT = 1,
    parameter int T_MAX    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_first,
    input  logic                             i_last,
    input  logic [NUM_X*WIDTH-1:0]           i_x,
    output logic [(NUM_H+NUM_X)*WIDTH-1:0]   o_cell_x,
    output logic [NUM_H*WIDTH-1:0]           o_cell_c,
    output logic                             o_cell_start,
    input  logic [NUM_H*WIDTH-1:0]           i_cell_h,
    input  logic [NUM_H*WIDTH-1:0]           i_cell_c,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [NUM_H*WIDTH-1:0]           o_h,
    output logic [NUM_H*WIDTH-1:0]           o_c,
    output logic [$clog2(T_MAX)-1:0]         o_step,
    output logic                             o_last,
    output logic                             o_ovf
`ifdef LSTM_HIST_EN
    ,
    input  logic [$clog2(T_MAX)-1:0]         i_hist_addr,
    output logic [NUM_H*WIDTH-1:0]           o_hist_h,
    output logic [NUM_H*WIDTH-1:0]           o_hist_c
`endif
);
    localparam int STEP_W = $clog2(T_MAX);
    localparam int HW     = NUM_H * WIDTH;
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(T_MAX - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                 state_q;
    logic [HW-1:0]          h_q, c_q, o_h_q, o_c_q;
    logic [NUM_X*WIDTH-1:0] x_q;
    logic                   last_q, ready_q, start_q, valid_q, o_last_q, ovf_q;
    logic [STEP_W-1:0]      step_q, step_d, o_step_q;
    logic [3:0]             wcnt_q;
    logic                   capture;

    assign capture = (state_q == WAIT) && (wcnt_q == 4'd1);

    // Step index once the presented result is consumed; saturates after an overflowing sequence.
    always_comb begin
        step_d = step_q + STEP_W'(1);
        if (o_last_q)
            step_d = '0;
        else if (step_q == STEP_MAX)
            step_d = step_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            h_q      <= '0;
            c_q      <= '0;
            x_q      <= '0;
            last_q   <= 1'b0;
            o_h_q    <= '0;
            o_c_q    <= '0;
            step_q   <= '0;
            o_step_q <= '0;
            o_last_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            ready_q  <= 1'b1;
            wcnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && ready_q) begin
                        x_q     <= i_x;
                        last_q  <= i_last;
                        ready_q <= 1'b0;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                        if (i_first) begin
                            h_q    <= '0;
                            c_q    <= '0;
                            step_q <= '0;
                            ovf_q  <= 1'b0;
                        end else if (step_q == STEP_MAX && !i_last) begin
                            ovf_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    wcnt_q  <= 4'(CELL_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        h_q      <= i_cell_h;
                        c_q      <= i_cell_c;
                        o_h_q    <= i_cell_h;
                        o_c_q    <= i_cell_c;
                        o_step_q <= step_q;
                        o_last_q <= last_q;
                        valid_q  <= 1'b1;
                        state_q  <= OUT;
                    end else begin
                        wcnt_q   <= wcnt_q - 4'd1;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        step_q  <= step_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_cell_start = start_q;
    assign o_cell_x     = {h_q, x_q};
    assign o_cell_c     = c_q;
    assign o_valid      = valid_q;
    assign o_h          = o_h_q;
    assign o_c          = o_c_q;
    assign o_step       = o_step_q;
    assign o_last       = o_last_q;
    assign o_ovf        = ovf_q;

`ifdef LSTM_HIST_EN
    logic [2*HW-1:0] hist_mem [T_MAX];
    logic [HW-1:0]   hist_h_q, hist_c_q;
    logic            hist_we;

    assign hist_we = capture && !ovf_q;

    always_ff @(posedge clk) begin
        if (hist_we)
            hist_mem[step_q] <= {i_cell_h, i_cell_c};
    end

    // Write-first read port so a same-cycle capture is visible immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_h_q <= '0;
            hist_c_q <= '0;
        end else if (hist_we && step_q == i_hist_addr) begin
            hist_h_q <= i_cell_h;
            hist_c_q <= i_cell_c;
        end else begin
            {hist_h_q, hist_c_q} <= hist_mem[i_hist_addr];
        end
    end

    assign o_hist_h = hist_h_q;
    assign o_hist_c = hist_c_q;
`endif

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - self-checking bench for lstm_seq_ctrl with a cycle-level step model.
module tb_lstm_seq_ctrl;
    localparam int WIDTH    = 32;
    localparam int NUM_X    = 2;
    localparam int NUM_H    = 1;
    localparam int CELL_LAT = 1;
    localparam int T_MAX    = 4;
    localparam int SW       = $clog2(T_MAX);

    logic clk, rst;
    logic i_valid, o_ready, i_first, i_last, o_cell_start, o_valid, i_ready, o_last, o_ovf;
    logic [NUM_X*WIDTH-1:0]         i_x;
    logic [(NUM_H+NUM_X)*WIDTH-1:0] o_cell_x;
    logic [NUM_H*WIDTH-1:0]         o_cell_c, i_cell_h, i_cell_c, o_h, o_c;
    logic [SW-1:0]                  o_step;
`ifdef LSTM_HIST_EN
    logic [SW-1:0]                  i_hist_addr;
    logic [NUM_H*WIDTH-1:0]         o_hist_h, o_hist_c;
`endif

    lstm_seq_ctrl #(.WIDTH(WIDTH), .NUM_X(NUM_X), .NUM_H(NUM_H), .CELL_LAT(CELL_LAT), .T_MAX(T_MAX)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_first(i_first), .i_last(i_last),
        .i_x(i_x), .o_cell_x(o_cell_x), .o_cell_c(o_cell_c), .o_cell_start(o_cell_start),
        .i_cell_h(i_cell_h), .i_cell_c(i_cell_c), .o_valid(o_valid), .i_ready(i_ready),
        .o_h(o_h), .o_c(o_c), .o_step(o_step), .o_last(o_last), .o_ovf(o_ovf)
`ifdef LSTM_HIST_EN
        , .i_hist_addr(i_hist_addr), .o_hist_h(o_hist_h), .o_hist_c(o_hist_c)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cell stand-in: result words are valid only in the cycle CELL_LAT after the start pulse.
    logic [31:0] cell_h_val, cell_c_val;
    int cyc = 0;
    int start_cyc = -100;
    initial begin
        i_cell_h = '0;
        i_cell_c = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (o_cell_start) start_cyc = cyc;
            if (cyc == start_cyc + CELL_LAT) begin
                i_cell_h = cell_h_val;
                i_cell_c = cell_c_val;
            end else begin
                i_cell_h = 32'hBAD0_0000 ^ 32'(cyc);
                i_cell_c = 32'hBAD1_0000 ^ 32'(cyc);
            end
        end
    end

    // Step model: age counts cycles since the accepting edge.
    bit          m_busy, m_last, m_ovf, m_olast;
    int          m_age, m_step, m_ostep;
    logic [31:0] m_h, m_c, m_oh, m_oc;
    logic [63:0] m_x;
`ifdef LSTM_HIST_EN
    logic [63:0] m_mem [T_MAX];
    bit          m_known [T_MAX];
    logic [63:0] m_hist;
    bit          m_hist_known;
`endif

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_age = 0; m_step = 0; m_last = 0; m_ovf = 0;
                m_h = 0; m_c = 0; m_x = 0; m_oh = 0; m_oc = 0; m_ostep = 0; m_olast = 0;
`ifdef LSTM_HIST_EN
                m_hist = 0; m_hist_known = 1;
`endif
            end
            chk("o_ready", o_ready, m_busy ? 0 : 1);
            chk("o_cell_start", o_cell_start, (m_busy && m_age == 1) ? 1 : 0);
            chk("o_valid", o_valid, (m_busy && m_age >= 2 + CELL_LAT) ? 1 : 0);
            chk("o_ovf", o_ovf, m_ovf);
            chk("o_h", o_h, m_oh);
            chk("o_c", o_c, m_oc);
            chk("o_step", o_step, m_ostep);
            chk("o_last", o_last, m_olast);
            if (m_busy && m_age >= 1 && m_age <= 1 + CELL_LAT) begin
                chk("o_cell_x", o_cell_x, {m_h, m_x});
                chk("o_cell_c", o_cell_c, m_c);
            end
`ifdef LSTM_HIST_EN
            if (m_hist_known) chk("o_hist", {o_hist_h, o_hist_c}, m_hist);
`endif
            if (!rst) begin
`ifdef LSTM_HIST_EN
                begin
                    bit we;
                    we = m_busy && m_age == 1 + CELL_LAT && !m_ovf;
                    if (we && m_step == int'(i_hist_addr)) begin
                        m_hist = {cell_h_val, cell_c_val}; m_hist_known = 1;
                    end else begin
                        m_hist = m_mem[i_hist_addr]; m_hist_known = m_known[i_hist_addr];
                    end
                    if (we) begin
                        m_mem[m_step] = {cell_h_val, cell_c_val}; m_known[m_step] = 1;
                    end
                end
`endif
                if (!m_busy) begin
                    if (i_valid) begin
                        m_busy = 1; m_age = 1; m_x = i_x; m_last = i_last;
                        if (i_first) begin
                            m_h = 0; m_c = 0; m_step = 0; m_ovf = 0;
                        end else if (m_step == T_MAX - 1 && !i_last) begin
                            m_ovf = 1;
                        end
                    end
                end else if (m_age == 1 + CELL_LAT) begin
                    m_h = cell_h_val; m_c = cell_c_val; m_oh = cell_h_val; m_oc = cell_c_val;
                    m_ostep = m_step; m_olast = m_last; m_age++;
                end else if (m_age >= 2 + CELL_LAT) begin
                    if (i_ready) begin
                        m_busy = 0;
                        if (m_olast) m_step = 0;
                        else if (m_step < T_MAX - 1) m_step++;
                    end
                end else begin
                    m_age++;
                end
            end
        end
    end

    logic [95:0] r_cx;
    logic [31:0] r_cc, r_h, r_c;
    logic [SW-1:0] r_step;
    logic r_ovf, r_last;

    task automatic do_step(input bit first, input bit last, input logic [63:0] x,
                           input logic [31:0] ch, input logic [31:0] cc, input int hold);
        cell_h_val = ch; cell_c_val = cc;
        i_valid = 1; i_first = first; i_last = last; i_x = x;
        @(posedge clk); #1;
        i_valid = 0; i_first = 0; i_last = 0; i_x = '1;
        @(negedge clk);
        r_cx = o_cell_x; r_cc = o_cell_c;
        for (int k = 0; k < 20 && !o_valid; k++) @(negedge clk);
        if (!o_valid) chk("valid_timeout", o_valid, 1);
        r_h = o_h; r_c = o_c; r_step = o_step; r_ovf = o_ovf; r_last = o_last;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            i_valid = 1; i_first = 1; i_x = 64'hFFFF_0000_EEEE_1111;
        end
        @(posedge clk); #1;
        i_valid = 0; i_first = 0; i_ready = 1;
        @(posedge clk); #1;
        i_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; i_valid = 0; i_first = 0; i_last = 0; i_x = '0; i_ready = 0;
        cell_h_val = 0; cell_c_val = 0;
`ifdef LSTM_HIST_EN
        i_hist_addr = '0;
`endif
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_ovf", o_ovf, 0);
        @(posedge clk); #1;

        do_step(1, 0, {32'd11, 32'd12}, 32'd5, 32'd9, 0);
        do_step(1, 0, {32'd3, 32'd7}, 32'h10, 32'h20, 0);
        chk("s1_cell_x", r_cx, {32'd0, 32'd3, 32'd7});
        chk("s1_cell_c", r_cc, 0);
        chk("s1_h", r_h, 32'h10);
        chk("s1_c", r_c, 32'h20);
        chk("s1_step", r_step, 0);
        do_step(0, 0, {32'd1, 32'd2}, 32'h11, 32'h21, 5);
        chk("s2_cell_x", r_cx, {32'h10, 32'd1, 32'd2});
        chk("s2_cell_c", r_cc, 32'h20);
        chk("s2_step", r_step, 1);
        @(negedge clk);
        chk("ready_after_out", o_ready, 1);
        @(posedge clk); #1;
        do_step(0, 0, {32'd4, 32'd5}, 32'h12, 32'h22, 0);
        chk("s3_step", r_step, 2);
        do_step(0, 0, {32'd6, 32'd8}, 32'h13, 32'h23, 0);
        chk("s4_step", r_step, 3);
        do_step(0, 0, {32'd9, 32'd10}, 32'h14, 32'h24, 0);
        chk("s5_step", r_step, 3);
        chk("s5_ovf", r_ovf, 1);
        do_step(1, 1, {32'd2, 32'd2}, 32'h30, 32'h40, 0);
        chk("s6_cell_x", r_cx, {32'd0, 32'd2, 32'd2});
        chk("s6_step", r_step, 0);
        chk("s6_ovf", r_ovf, 0);
        chk("s6_last", r_last, 1);
        do_step(0, 0, {32'd5, 32'd6}, 32'h31, 32'h41, 0);
        chk("s7_cell_x", r_cx, {32'h30, 32'd5, 32'd6});
        chk("s7_cell_c", r_cc, 32'h40);
        chk("s7_step", r_step, 0);

        cell_h_val = 32'h77; cell_c_val = 32'h88;
        i_valid = 1; i_x = {32'd1, 32'd1};
        @(posedge clk); #1;
        i_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rw_ready", o_ready, 1);
        chk("rw_valid", o_valid, 0);
        chk("rw_h", o_h, 0);
        chk("rw_c", o_c, 0);
        chk("rw_ovf", o_ovf, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

`ifdef LSTM_HIST_EN
        do_step(1, 0, {32'd1, 32'd0}, 32'd1, 32'd11, 0);
        do_step(0, 0, {32'd2, 32'd0}, 32'd2, 32'd12, 0);
        do_step(0, 1, {32'd3, 32'd0}, 32'd3, 32'd13, 0);
        for (int a = 0; a < 3; a++) begin
            i_hist_addr = SW'(a);
            @(posedge clk); #1;
            @(negedge clk);
            chk("hist_h", o_hist_h, 32'(a + 1));
            chk("hist_c", o_hist_c, 32'(a + 11));
        end
`endif
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
